// File: rtl/intmul_iter_pkg.sv
// Shared types, DSP tile geometry and sizing helpers for the iterative tiled multiplier.
// DSP tile sizes come from the DSP_A_U / DSP_B_U macros; the defaults are the unsigned portion of a 27x18 DSP.
`ifndef DSP_A_U
`define DSP_A_U 26
`endif
`ifndef DSP_B_U
`define DSP_B_U 17
`endif

package intmul_iter_pkg;

  localparam int DSP_A    = `DSP_A_U;
  localparam int DSP_B    = `DSP_B_U;
  localparam int DEF_LOGA = 34;
  localparam int DEF_LOGB = 43;

  typedef struct packed {
    int loga;
    int logb;
    int ff_in;
    int ff_mul;
    int use_csa;
  } intmul_iter_params_t;

  function automatic int n_chunks(input int w, input int u);
    return (w + u - 1) / u;
  endfunction

  // Cycles from the accept edge to out_valid.
  function automatic int intmul_iter_lat(input intmul_iter_params_t p);
    return n_chunks(p.logb, DSP_B) + p.ff_mul;
  endfunction

  localparam int N_A   = n_chunks(DEF_LOGA, DSP_A);
  localparam int N_B   = n_chunks(DEF_LOGB, DSP_B);
  localparam int ROW_W = DEF_LOGA + DSP_B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/intmul_row.sv
// Combinational LOGA x DSP_B row product built from DSP_A x DSP_B tiles.
// Tile products are summed either by a carry-save tree plus one final adder or by a plain adder chain.
module intmul_row
  import intmul_iter_pkg::*;
#(
  parameter int LOGA    = DEF_LOGA,
  parameter int USE_CSA = 0
) (
  input  logic [LOGA-1:0]       a_i,
  input  logic [DSP_B-1:0]      b_i,
  output logic [LOGA+DSP_B-1:0] p_o
);

  localparam int NA = n_chunks(LOGA, DSP_A);
  localparam int RW = LOGA + DSP_B;

  logic [NA*DSP_A-1:0] a_ext;
  logic [RW-1:0]       term [NA];

  assign a_ext = (NA*DSP_A)'(a_i);

  // Tiles are exact; truncation to RW only drops bits that are always zero.
  always_comb begin
    for (int i = 0; i < NA; i++) begin
      term[i] = RW'({{DSP_B{1'b0}}, a_ext[i*DSP_A +: DSP_A]} * {{DSP_A{1'b0}}, b_i}) << (i*DSP_A);
    end
  end

  if (USE_CSA != 0) begin : g_csa
    logic [RW-1:0] s, c, s_n, c_n;
    always_comb begin
      s   = '0;
      c   = '0;
      s_n = '0;
      c_n = '0;
      for (int i = 0; i < NA; i++) begin
        s_n = s ^ c ^ term[i];
        c_n = ((s & c) | (s & term[i]) | (c & term[i])) << 1;
        s   = s_n;
        c   = c_n;
      end
    end
    assign p_o = s + c;
  end else begin : g_chain
    logic [RW-1:0] sum;
    always_comb begin
      sum = '0;
      for (int i = 0; i < NA; i++) begin
        sum = sum + term[i];
      end
    end
    assign p_o = sum;
  end

endmodule

// File: rtl/intmul_iter_tiled.sv
// Iterative unsigned LOGA x LOGB multiplier: one DSP_B-wide chunk of B per cycle, shifted into an accumulator.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both high; C holds while out_valid && !out_ready.
module intmul_iter_tiled
  import intmul_iter_pkg::*;
#(
  parameter int LOGA    = DEF_LOGA,
  parameter int LOGB    = DEF_LOGB,
  parameter int FF_IN   = 1,
  parameter int FF_MUL  = 1,
  parameter int USE_CSA = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LOGA-1:0]      A,
  input  logic [LOGB-1:0]      B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LOGA+LOGB-1:0] C,
  output logic                 busy,
  output state_e               dbg_state
);

  // Operands are always captured on accept, so latency is the same for either FF_IN setting.
  localparam intmul_iter_params_t P = '{loga: LOGA, logb: LOGB, ff_in: FF_IN,
                                        ff_mul: FF_MUL, use_csa: USE_CSA};
  localparam int NB  = n_chunks(LOGB, DSP_B);
  localparam int LAT = intmul_iter_lat(P);
  localparam int RW  = LOGA + DSP_B;
  localparam int PW  = LOGA + LOGB;
  localparam int KW  = (LAT > 1) ? $clog2(LAT) : 1;

  state_e          state_q, state_d;
  logic [KW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [LOGA-1:0] a_q;
  logic [LOGB-1:0] b_q;
  logic            accept, issue, add_en, last_step;
  logic [DSP_B-1:0] b_chunk;
  logic [RW-1:0]   row, add_row;
  logic [KW-1:0]   add_idx;

  // cnt steps through LAT cycles of MUL; rows are issued only while cnt < NB.
  assign last_step = (cnt_q == KW'(LAT-1));
  assign issue     = (state_q == MUL) && (int'(cnt_q) < NB);
  assign b_chunk   = DSP_B'((NB*DSP_B)'(b_q) >> (int'(cnt_q) * DSP_B));

  intmul_row #(
    .LOGA    (LOGA),
    .USE_CSA (USE_CSA)
  ) u_row (
    .a_i (a_q),
    .b_i (b_chunk),
    .p_o (row)
  );

  if (FF_MUL != 0) begin : g_pipe
    logic [RW-1:0] prod_q;
    logic [KW-1:0] pidx_q;
    logic          pvld_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_q <= '0;
        pidx_q <= '0;
        pvld_q <= 1'b0;
      end else begin
        pvld_q <= issue;
        if (issue) begin
          prod_q <= row;
          pidx_q <= cnt_q;
        end
      end
    end
    assign add_row = prod_q;
    assign add_idx = pidx_q;
    assign add_en  = pvld_q;
  end else begin : g_direct
    assign add_row = row;
    assign add_idx = cnt_q;
    assign add_en  = issue;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = MUL;
      end
      MUL: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = in_valid ? MUL : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (accept) begin
      cnt_d = '0;
      acc_d = '0;
    end else begin
      if ((state_q == MUL) && !last_step) cnt_d = cnt_q + 1'b1;
      // Row bits shifted above PW-1 are always zero and are dropped.
      if (add_en) acc_d = acc_q + (PW'(add_row) << (int'(add_idx) * DSP_B));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      if (accept) begin
        a_q <= A;
        b_q <= B;
      end
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign C         = acc_q;
  assign dbg_state = state_q;

endmodule
